// File: rtl/cache_axi_read_arbiter.sv
// cache_axi_read_arbiter
// Shares a single AXI read master (AR/R) between the i$ refill path and the
// d$ refill/uncached path. One transaction is in flight at a time; R beats are
// steered to whichever requester owns the current transaction.
//
// Optional build macro:
//   ARB_ROUND_ROBIN_EN - when defined, ties are broken round-robin using a
//                        last_grant flop. When undefined, data always beats
//                        inst on a same-cycle tie.
module cache_axi_read_arbiter #(
  parameter logic [7:0] INST_ARLEN = 8'd15,
  parameter logic [7:0] DATA_ARLEN = 8'd15,
  parameter logic [3:0] INST_ARID  = 4'd0,
  parameter logic [3:0] DATA_ARID  = 4'd1
) (
  input  logic        clk,
  input  logic        rst,

  // i$ side
  input  logic [31:0] inst_addr_mmu,
  input  logic        inst_read_req,
  output logic        inst_addr_ok,
  output logic [31:0] inst_read_data,
  output logic        inst_mmu_valid,
  output logic        inst_mmu_last,

  // d$ side
  input  logic [31:0] data_addr_mmu,
  input  logic        data_read_req,
  input  logic        data_uncached,
  input  logic [2:0]  data_size,
  output logic        data_addr_ok,
  output logic [31:0] data_read_data,
  output logic        data_mmu_valid,
  output logic        data_mmu_last,

  output logic        rd_err,

  // AXI AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  // AXI R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  // Cached refills always move full 32-bit words.
  localparam logic [2:0] WORD_SIZE = 3'd2;

  // Owner encoding: 0 = inst, 1 = data.
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  state_e      state_q,   state_d;
  logic        owner_q,   owner_d;
  logic        arvalid_q, arvalid_d;
  logic [31:0] araddr_q,  araddr_d;
  logic [3:0]  arid_q,    arid_d;
  logic [7:0]  arlen_q,   arlen_d;
  logic [2:0]  arsize_q,  arsize_d;

  logic any_req;
  logic grant_data;
  logic ar_hs;
  logic r_beat;

  // rid is not used for steering (only one transaction is ever open) and
  // rresp[0] does not distinguish any error we report.
  logic unused_r;
  assign unused_r = ^{rid, rresp[0]};

  assign any_req = inst_read_req | data_read_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q;  // 0 = inst granted last, 1 = data granted last

  // On a tie, hand the bus to whoever did not win last time.
  always_comb begin
    grant_data = data_read_req & (~inst_read_req | (last_grant_q == OWN_INST));
  end

  // Remember the most recent winner whenever a grant is made.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= OWN_INST;
    end else if (state_q == S_IDLE && any_req) begin
      last_grant_q <= grant_data;
    end
  end
`else
  // Fixed priority: data wins whenever it is requesting.
  always_comb begin
    grant_data = data_read_req;
  end
`endif

  // State and AR channel registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_INST;
      arvalid_q <= 1'b0;
      araddr_q  <= 32'd0;
      arid_q    <= 4'd0;
      arlen_q   <= 8'd0;
      arsize_q  <= 3'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arid_q    <= arid_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
    end
  end

  // Next-state: grant in IDLE, hold AR until accepted, wait for rlast.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arid_d    = arid_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d   = S_ADDR;
          arvalid_d = 1'b1;
          owner_d   = grant_data;
          if (grant_data) begin
            araddr_d = data_addr_mmu;
            arid_d   = DATA_ARID;
            arlen_d  = data_uncached ? 8'd0 : DATA_ARLEN;
            arsize_d = data_uncached ? data_size : WORD_SIZE;
          end else begin
            araddr_d = inst_addr_mmu;
            arid_d   = INST_ARID;
            arlen_d  = INST_ARLEN;
            arsize_d = WORD_SIZE;
          end
        end
      end
      S_ADDR: begin
        if (arvalid_q && arready) begin
          state_d   = S_DATA;
          arvalid_d = 1'b0;
        end
      end
      S_DATA: begin
        if (rvalid && rlast) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        arvalid_d = 1'b0;
      end
    endcase
  end

  // Handshake and beat qualifiers.
  assign ar_hs  = (state_q == S_ADDR) & arvalid_q & arready;
  assign rready = (state_q == S_DATA);
  assign r_beat = rvalid & rready;

  // Address-accept pulses go only to the current owner.
  assign inst_addr_ok = ar_hs & (owner_q == OWN_INST);
  assign data_addr_ok = ar_hs & (owner_q == OWN_DATA);

  // Beat steering: data bus is shared, valid/last pick the owner.
  assign inst_read_data = rdata;
  assign data_read_data = rdata;
  assign inst_mmu_valid = r_beat & (owner_q == OWN_INST);
  assign data_mmu_valid = r_beat & (owner_q == OWN_DATA);
  assign inst_mmu_last  = r_beat & (owner_q == OWN_INST) & rlast;
  assign data_mmu_last  = r_beat & (owner_q == OWN_DATA) & rlast;

  // SLVERR/DECERR flagged per beat; the beat is still delivered.
  assign rd_err = r_beat & rresp[1];

  // AR channel outputs.
  assign arvalid = arvalid_q;
  assign araddr  = araddr_q;
  assign arid    = arid_q;
  assign arlen   = arlen_q;
  assign arsize  = arsize_q;
  assign arburst = 2'd1;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

endmodule

// File: tb/tb_cache_axi_read_arbiter.sv
// Directed self-checking bench for cache_axi_read_arbiter.
module tb_cache_axi_read_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] inst_addr_mmu;
  logic        inst_read_req;
  logic        inst_addr_ok;
  logic [31:0] inst_read_data;
  logic        inst_mmu_valid;
  logic        inst_mmu_last;
  logic [31:0] data_addr_mmu;
  logic        data_read_req;
  logic        data_uncached;
  logic [2:0]  data_size;
  logic        data_addr_ok;
  logic [31:0] data_read_data;
  logic        data_mmu_valid;
  logic        data_mmu_last;
  logic        rd_err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int n_assert = 0;
  int n_fail   = 0;

  cache_axi_read_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_addr_mmu(inst_addr_mmu), .inst_read_req(inst_read_req),
    .inst_addr_ok(inst_addr_ok), .inst_read_data(inst_read_data),
    .inst_mmu_valid(inst_mmu_valid), .inst_mmu_last(inst_mmu_last),
    .data_addr_mmu(data_addr_mmu), .data_read_req(data_read_req),
    .data_uncached(data_uncached), .data_size(data_size),
    .data_addr_ok(data_addr_ok), .data_read_data(data_read_data),
    .data_mmu_valid(data_mmu_valid), .data_mmu_last(data_mmu_last),
    .rd_err(rd_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: observed no end of test, expected end before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the drive/check slot of the next cycle (2 units after posedge).
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  // Drive n beats of a len-beat burst; rlast only on beat len-1.
  task automatic burst(input int n, input int len, input bit to_inst, input int err_beat);
    for (int k = 0; k < n; k++) begin
      rvalid = 1'b1;
      rdata  = 32'hA500_0000 + (to_inst ? 32'h0 : 32'h10_0000) + k;
      rlast  = (k == len - 1);
      rresp  = (k == err_beat) ? 2'b10 : 2'b00;
      rid    = to_inst ? 4'd0 : 4'd1;
      #1;
      chk("beat_rready",     rready,         1'b1);
      chk("beat_inst_valid", inst_mmu_valid, to_inst);
      chk("beat_data_valid", data_mmu_valid, !to_inst);
      chk("beat_inst_last",  inst_mmu_last,  to_inst && (k == len - 1));
      chk("beat_data_last",  data_mmu_last,  !to_inst && (k == len - 1));
      chk("beat_data", to_inst ? inst_read_data : data_read_data,
          32'hA500_0000 + (to_inst ? 32'h0 : 32'h10_0000) + k);
      chk("beat_rd_err",     rd_err,         k == err_beat);
      chk("beat_addr_ok",    inst_addr_ok | data_addr_ok, 1'b0);
      chk("beat_arvalid",    arvalid,        1'b0);
      if (k != n - 1 || n == len) nxt();
    end
    if (n == len) begin
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
    end
  endtask

  initial begin
    rst = 1'b0;
    inst_addr_mmu = 32'd0; inst_read_req = 1'b0;
    data_addr_mmu = 32'd0; data_read_req = 1'b0;
    data_uncached = 1'b0;  data_size = 3'd0;
    arready = 1'b0;
    rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b0; rvalid = 1'b0;

    // ---- reset state ----
    repeat (3) nxt();
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_araddr",  araddr,  32'd0);
    chk("rst_arid",    arid,    4'd0);
    chk("rst_arlen",   arlen,   8'd0);
    chk("rst_arsize",  arsize,  3'd0);
    chk("rst_rready",  rready,  1'b0);
    chk("rst_arburst", arburst, 2'd1);
    chk("rst_const",   {arlock, arcache, arprot}, 9'd0);
    chk("rst_outs", {inst_addr_ok, data_addr_ok, inst_mmu_valid, data_mmu_valid,
                     inst_mmu_last, data_mmu_last, rd_err}, 7'd0);
    rst = 1'b1;
    nxt();

    // ---- single i$ refill ----
    arready = 1'b1;
    inst_addr_mmu = 32'h1FC0_0040; inst_read_req = 1'b1;
    #1;
    chk("t1_arvalid_lat", arvalid, 1'b0);
    chk("t1_ok_early",    inst_addr_ok, 1'b0);
    nxt();
    chk("t1_arvalid", arvalid, 1'b1);
    chk("t1_araddr",  araddr,  32'h1FC0_0040);
    chk("t1_arid",    arid,    4'd0);
    chk("t1_arlen",   arlen,   8'd15);
    chk("t1_arsize",  arsize,  3'd2);
    chk("t1_inst_ok", inst_addr_ok, 1'b1);
    chk("t1_data_ok", data_addr_ok, 1'b0);
    chk("t1_rready_addr", rready, 1'b0);
    inst_read_req = 1'b0;
    nxt();
    chk("t1_arvalid_drop", arvalid, 1'b0);
    chk("t1_ok_once",      inst_addr_ok, 1'b0);
    burst(16, 16, 1'b1, -1);
    chk("t1_idle_rready", rready, 1'b0);

    // ---- simultaneous requests: data first, inst after bubble ----
    inst_addr_mmu = 32'h0000_0100; inst_read_req = 1'b1;
    data_addr_mmu = 32'h0000_0200; data_read_req = 1'b1;
    nxt();
    chk("t2_d_araddr",  araddr, 32'h0000_0200);
    chk("t2_d_arid",    arid,   4'd1);
    chk("t2_d_arlen",   arlen,  8'd15);
    chk("t2_d_ok",      data_addr_ok, 1'b1);
    chk("t2_i_ok_no",   inst_addr_ok, 1'b0);
    data_read_req = 1'b0;
    nxt();
    burst(16, 16, 1'b0, -1);
    chk("t2_bubble_arvalid", arvalid, 1'b0);
    nxt();
    chk("t2_i_arvalid", arvalid, 1'b1);
    chk("t2_i_araddr",  araddr,  32'h0000_0100);
    chk("t2_i_arid",    arid,    4'd0);
    chk("t2_i_ok",      inst_addr_ok, 1'b1);
    inst_read_req = 1'b0;
    nxt();
    burst(16, 16, 1'b1, -1);

    // ---- uncached data read ----
    data_addr_mmu = 32'hBFD0_F000; data_read_req = 1'b1;
    data_uncached = 1'b1; data_size = 3'd2;
    nxt();
    chk("t3_araddr", araddr, 32'hBFD0_F000);
    chk("t3_arlen",  arlen,  8'd0);
    chk("t3_arsize", arsize, 3'd2);
    chk("t3_arid",   arid,   4'd1);
    chk("t3_ok",     data_addr_ok, 1'b1);
    data_read_req = 1'b0;
    nxt();
    burst(1, 1, 1'b0, -1);

    // ---- arready backpressure, uncached byte read ----
    arready = 1'b0;
    data_addr_mmu = 32'h1234_5678; data_read_req = 1'b1;
    data_uncached = 1'b1; data_size = 3'd0;
    nxt();
    for (int c = 0; c < 5; c++) begin
      chk("t4_arvalid_hold", arvalid, 1'b1);
      chk("t4_araddr_hold",  araddr,  32'h1234_5678);
      chk("t4_arsize_hold",  arsize,  3'd0);
      chk("t4_arlen_hold",   arlen,   8'd0);
      chk("t4_ok_low",       data_addr_ok, 1'b0);
      nxt();
    end
    arready = 1'b1;
    #1;
    chk("t4_ok_pulse", data_addr_ok, 1'b1);
    data_read_req = 1'b0; data_uncached = 1'b0;
    nxt();
    chk("t4_arvalid_drop", arvalid, 1'b0);
    burst(1, 1, 1'b0, -1);

    // ---- error response on beat 3 ----
    inst_addr_mmu = 32'h1FC0_0400; inst_read_req = 1'b1;
    nxt();
    chk("t5_ok", inst_addr_ok, 1'b1);
    inst_read_req = 1'b0;
    nxt();
    burst(16, 16, 1'b1, 2);

    // ---- reset during beat 7 ----
    inst_addr_mmu = 32'h1FC0_0800; inst_read_req = 1'b1;
    nxt();
    inst_read_req = 1'b0;
    nxt();
    burst(7, 16, 1'b1, -1);
    rst = 1'b0;
    #1;
    chk("t6_arvalid", arvalid, 1'b0);
    chk("t6_rready",  rready,  1'b0);
    chk("t6_valids",  {inst_mmu_valid, data_mmu_valid}, 2'b00);
    chk("t6_araddr",  araddr,  32'd0);
    rvalid = 1'b0; rlast = 1'b0;
    nxt();
    rst = 1'b1;
    nxt();
    inst_addr_mmu = 32'h0000_2000; inst_read_req = 1'b1;
    nxt();
    chk("t6_new_arvalid", arvalid, 1'b1);
    chk("t6_new_araddr",  araddr,  32'h0000_2000);
    chk("t6_new_ok",      inst_addr_ok, 1'b1);
    inst_read_req = 1'b0;
    nxt();
    burst(16, 16, 1'b1, -1);
    chk("t6_end_idle", rready, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
